// File: rtl/fp_seq_platform_if.sv
// Host <-> sequencer operand/result handshake bundle.
interface fp_seq_platform_if;
   logic [31:0] din;
   logic        din_rdy;
   logic [31:0] dout;
   logic        dout_rdy;
   logic        din_req;

   // Host side drives operands and consumes results.
   modport master (
      output din,
      output din_rdy,
      input  dout,
      input  dout_rdy,
      input  din_req
   );

   // Sequencer side consumes operands and produces results.
   modport slave (
      input  din,
      input  din_rdy,
      output dout,
      output dout_rdy,
      output din_req
   );
endinterface

// File: rtl/fp_seq_platform.sv
// Byte-code sequencer with a 16 KiB program ROM, four 32-bit registers and
// simple IEEE754 single-precision helpers (negate, multiply by two).
// Build option: define ILLEGAL_TRAP_EN to halt on undefined opcodes
// (PC left on the offending byte); otherwise they execute as 1-byte NOPs.
module fp_seq_platform (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sw_din,
   input  logic        we_n_in,
   input  logic [13:0] sw_addr,
   input  logic        mode,
   fp_seq_platform_if.slave bus
);

   localparam int unsigned ROM_SIZE = 16384;
   localparam int unsigned AW       = 14;
   localparam int unsigned DW       = 32;
   localparam int unsigned NREGS    = 4;
   localparam int unsigned NOPS     = 5;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_IN    = 8'h01;
   localparam logic [7:0] OP_OUT   = 8'h02;
   localparam logic [7:0] OP_LDI   = 8'h03;
   localparam logic [7:0] OP_ADD   = 8'h04;
   localparam logic [7:0] OP_FNEG  = 8'h05;
   localparam logic [7:0] OP_FMUL2 = 8'h06;
   localparam logic [7:0] OP_JMP   = 8'h07;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_OPER,
      S_EXEC,
      S_WAIT_IN,
      S_HALT
   } state_t;

   logic [7:0]                 rom_mem [ROM_SIZE];
   logic [7:0]                 rom_q;

   state_t                     state_q, state_n;
   logic [AW-1:0]              pc_q, pc_n;
   logic [7:0]                 opc_q, opc_n;
   logic [NOPS-1:0][7:0]       ops_q, ops_n;
   logic [2:0]                 cnt_q, cnt_n;
   logic [2:0]                 idx_q, idx_n;
   logic                       phase_q, phase_n;
   logic [NREGS-1:0][DW-1:0]   regs_q, regs_n;
   logic [DW-1:0]              dout_q, dout_n;
   logic                       dout_rdy_q, dout_rdy_n;
   logic                       din_req_q, din_req_n;
   logic                       trap_c;
   logic [1:0]                 ra_c;
   logic [1:0]                 rb_c;

   // Number of operand bytes following each opcode.
   function automatic logic [2:0] op_len(input logic [7:0] op);
      logic [2:0] n;
      case (op)
         OP_IN, OP_OUT, OP_FNEG, OP_FMUL2: n = 3'd1;
         OP_ADD, OP_JMP:                   n = 3'd2;
         OP_LDI:                           n = 3'd5;
         default:                          n = 3'd0;
      endcase
      return n;
   endfunction

   // IEEE754 single x2: denormals shift into the exponent, inf/NaN pass, overflow saturates to inf.
   function automatic logic [31:0] fmul2(input logic [31:0] x);
      logic [7:0]  e;
      logic [31:0] y;
      e = x[30:23];
      if (e == 8'd0)        y = {x[31], x[29:0], 1'b0};
      else if (e == 8'hFF)  y = x;
      else if (e == 8'hFE)  y = {x[31], 8'hFF, 23'd0};
      else                  y = {x[31], e + 8'd1, x[22:0]};
      return y;
   endfunction

`ifdef ILLEGAL_TRAP_EN
   // Opcodes the sequencer actually implements.
   function automatic logic op_legal(input logic [7:0] op);
      return (op <= OP_JMP) || (op == OP_HALT);
   endfunction

   assign trap_c = !op_legal(rom_q);
`else
   assign trap_c = 1'b0;
`endif

   assign ra_c = ops_q[0][1:0];
   assign rb_c = ops_q[1][1:0];

   // Host ROM write port, active only in load mode.
   always_ff @(posedge clk) begin
      if (mode && !we_n_in) rom_mem[sw_addr] <= sw_din;
   end

   // Synchronous ROM read addressed by the PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rom_q <= 8'd0;
      else      rom_q <= rom_mem[pc_q];
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         opc_q      <= OP_NOP;
         ops_q      <= '0;
         cnt_q      <= 3'd0;
         idx_q      <= 3'd0;
         phase_q    <= 1'b0;
         regs_q     <= '0;
         dout_q     <= '0;
         dout_rdy_q <= 1'b0;
         din_req_q  <= 1'b0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         opc_q      <= opc_n;
         ops_q      <= ops_n;
         cnt_q      <= cnt_n;
         idx_q      <= idx_n;
         phase_q    <= phase_n;
         regs_q     <= regs_n;
         dout_q     <= dout_n;
         dout_rdy_q <= dout_rdy_n;
         din_req_q  <= din_req_n;
      end
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      opc_n      = opc_q;
      ops_n      = ops_q;
      cnt_n      = cnt_q;
      idx_n      = idx_q;
      phase_n    = phase_q;
      regs_n     = regs_q;
      dout_n     = dout_q;
      dout_rdy_n = 1'b0;
      din_req_n  = din_req_q;

      if (mode) begin
         state_n   = S_FETCH;
         pc_n      = '0;
         din_req_n = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               state_n = S_DECODE;
            end
            S_DECODE: begin
               opc_n   = rom_q;
               idx_n   = 3'd0;
               phase_n = 1'b0;
               if (trap_c) begin
                  state_n = S_HALT;
               end else begin
                  pc_n    = pc_q + AW'(1);
                  cnt_n   = op_len(rom_q);
                  state_n = (op_len(rom_q) == 3'd0) ? S_EXEC : S_OPER;
               end
            end
            S_OPER: begin
               // Phase 0 lets the ROM read the byte at PC; phase 1 captures it.
               if (!phase_q) begin
                  phase_n = 1'b1;
               end else begin
                  ops_n[idx_q] = rom_q;
                  idx_n        = idx_q + 3'd1;
                  cnt_n        = cnt_q - 3'd1;
                  pc_n         = pc_q + AW'(1);
                  phase_n      = 1'b0;
                  if (cnt_q == 3'd1) state_n = S_EXEC;
               end
            end
            S_EXEC: begin
               state_n = S_FETCH;
               case (opc_q)
                  OP_IN: begin
                     din_req_n = 1'b1;
                     state_n   = S_WAIT_IN;
                  end
                  OP_OUT: begin
                     dout_n     = regs_q[ra_c];
                     dout_rdy_n = 1'b1;
                  end
                  OP_LDI:   regs_n[ra_c] = {ops_q[4], ops_q[3], ops_q[2], ops_q[1]};
                  OP_ADD:   regs_n[ra_c] = regs_q[ra_c] + regs_q[rb_c];
                  OP_FNEG:  regs_n[ra_c][31] = ~regs_q[ra_c][31];
                  OP_FMUL2: regs_n[ra_c] = fmul2(regs_q[ra_c]);
                  OP_JMP:   pc_n = {ops_q[1][5:0], ops_q[0]};
                  OP_HALT:  state_n = S_HALT;
                  default:  ;
               endcase
            end
            S_WAIT_IN: begin
               if (din_req_q && bus.din_rdy) begin
                  regs_n[ra_c] = bus.din;
                  din_req_n    = 1'b0;
                  state_n      = S_FETCH;
               end
            end
            S_HALT: begin
               state_n = S_HALT;
            end
            default: begin
               state_n = S_FETCH;
            end
         endcase
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_rdy = dout_rdy_q;
   assign bus.din_req  = din_req_q;

endmodule

// File: tb/tb_fp_seq_platform.sv
// Directed bench for fp_seq_platform: ROM loading, operand handshake,
// float helpers, arithmetic/jump, reset and load-mode abort.
module tb_fp_seq_platform;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic        we_n_in;
   logic [7:0]  sw_din;
   logic [13:0] sw_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] prog[$];

   fp_seq_platform_if bus();

   fp_seq_platform dut (
      .clk     (clk),
      .rst     (rst),
      .sw_din  (sw_din),
      .we_n_in (we_n_in),
      .sw_addr (sw_addr),
      .mode    (mode),
      .bus     (bus)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write prog[] at base in load mode; leaves mode=1 for the caller.
   task automatic load_prog(input logic [13:0] base);
      mode = 1'b1;
      foreach (prog[i]) begin
         sw_addr = base + 14'(i);
         sw_din  = prog[i];
         we_n_in = 1'b0;
         @(negedge clk);
      end
      we_n_in = 1'b1;
      @(negedge clk);
   endtask

   // Wait (bounded) for a result strobe, check its value and that it lasts one cycle.
   task automatic wait_strobe(input string tag, input logic [31:0] exp, input int budget);
      int n = 0;
      while (bus.dout_rdy !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_pulse"}, 32'(bus.dout_rdy), 32'd1);
      check(tag, bus.dout, exp);
      @(negedge clk);
      check({tag, "_low"}, 32'(bus.dout_rdy), 32'd0);
   endtask

   // Wait (bounded) for the operand request.
   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (bus.din_req !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.din_req), 32'd1);
   endtask

   // Observe for a while: no strobe at all and a constant din_req level.
   task automatic quiet(input string tag, input int cycles, input logic req_lvl);
      int strobes = 0;
      int req_bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.dout_rdy !== 1'b0) strobes++;
         if (bus.din_req !== req_lvl) req_bad++;
      end
      check({tag, "_strobes"}, 32'(strobes), 32'd0);
      check({tag, "_req"}, 32'(req_bad), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      mode        = 1'b1;
      we_n_in     = 1'b1;
      sw_din      = 8'h00;
      sw_addr     = 14'h0000;
      bus.din     = 32'h0;
      bus.din_rdy = 1'b0;

      // Reset state
      #2 rst = 1'b0;
      #1;
      check("rst_dout", bus.dout, 32'h0);
      check("rst_dout_rdy", 32'(bus.dout_rdy), 32'd0);
      check("rst_din_req", 32'(bus.din_req), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Program A: IN R0; FMUL2 R0; OUT R0; FNEG R0; OUT R0; HALT
      prog = '{8'h01, 8'h00, 8'h06, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h00, 8'hFF};
      load_prog(14'h0000);
      mode = 1'b0;
      wait_req("a_req", 100);
      quiet("a_stall", 50, 1'b1);
      bus.din     = 32'h4020_0000;
      bus.din_rdy = 1'b1;
      @(negedge clk);
      check("a_req_drop", 32'(bus.din_req), 32'd0);
      bus.din_rdy = 1'b0;
      bus.din     = 32'h0;
      wait_strobe("a_out_pos", 32'h40A0_0000, 100);
      wait_strobe("a_out_neg", 32'hC0A0_0000, 100);
      quiet("a_halt", 40, 1'b0);
      check("a_halt_dout", bus.dout, 32'hC0A0_0000);

      // Rerun via load mode, then reset while the operand is pending
      mode = 1'b1;
      @(negedge clk);
      mode = 1'b0;
      wait_req("b_req", 100);
      check("b_dout_held", bus.dout, 32'hC0A0_0000);
      #1 rst = 1'b0;
      #1;
      check("b_rst_dout", bus.dout, 32'h0);
      check("b_rst_dout_rdy", 32'(bus.dout_rdy), 32'd0);
      check("b_rst_din_req", 32'(bus.din_req), 32'd0);
      @(negedge clk);
      bus.din     = 32'h4020_0000;
      bus.din_rdy = 1'b1;
      rst         = 1'b1;
      wait_req("c_req", 100);
      @(negedge clk);
      check("c_fast_drop", 32'(bus.din_req), 32'd0);
      bus.din_rdy = 1'b0;
      wait_strobe("c_out_pos", 32'h40A0_0000, 100);
      wait_strobe("c_out_neg", 32'hC0A0_0000, 100);

      // FMUL2 edge cases: LDI R0,x; FMUL2 R0; OUT R0 (x4), HALT
      prog = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h06, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h7F, 8'h06, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h06, 8'h00, 8'h02, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h06, 8'h00, 8'h02, 8'h00,
               8'hFF};
      load_prog(14'h0000);
      mode = 1'b0;
      wait_strobe("fm_ovf_inf", 32'h7F80_0000, 200);
      wait_strobe("fm_nan", 32'h7FC0_0000, 200);
      wait_strobe("fm_denorm", 32'h0080_0000, 200);
      wait_strobe("fm_negzero", 32'h8000_0000, 200);

      // LDI R1=-1; LDI R2=2; ADD R1,R2; OUT R1; JMP back to OUT
      prog = '{8'h03, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h03, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h04, 8'h01, 8'h02,
               8'h02, 8'h01,
               8'h07, 8'h0F, 8'h00};
      load_prog(14'h0000);
      mode = 1'b0;
      wait_strobe("add_out0", 32'h0000_0001, 200);
      wait_strobe("jmp_out1", 32'h0000_0001, 100);
      wait_strobe("jmp_out2", 32'h0000_0001, 100);

      // LDI R3; undefined 0x42; OUT R3; HALT
      prog = '{8'h03, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h42, 8'h02, 8'h03, 8'hFF};
      load_prog(14'h0000);
      mode = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      quiet("illegal_trap", 120, 1'b0);
      check("illegal_dout", bus.dout, 32'h0000_0001);
`else
      wait_strobe("illegal_nop", 32'h1234_5678, 200);
`endif

      // PC wrap: OUT R3; JMP 0x3FFF; ROM[0x3FFF]=NOP falls through to 0
      prog = '{8'h02, 8'h03, 8'h07, 8'hFF, 8'h3F};
      load_prog(14'h0000);
      prog = '{8'h00};
      load_prog(14'h3FFF);
      mode = 1'b0;
      wait_strobe("wrap_out0", 32'h1234_5678, 100);
      wait_strobe("wrap_out1", 32'h1234_5678, 100);

      // Load mode aborts a pending IN; dout is kept
      prog = '{8'h01, 8'h00, 8'hFF};
      load_prog(14'h0000);
      mode = 1'b0;
      wait_req("abort_req", 100);
      mode = 1'b1;
      @(negedge clk);
      check("abort_req_drop", 32'(bus.din_req), 32'd0);
      check("abort_dout_kept", bus.dout, 32'h1234_5678);
      quiet("abort_idle", 10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_seq_platform.md
Name: fp_seq_platform

Overview:
- Self-contained virtual platform: a 16 KiB byte-wide program ROM and a small byte-code sequencer.
- The sequencer has four 32-bit registers, a 32-bit input handshake and a 32-bit output strobe.
- The host loads the ROM while `mode`=1. With `mode`=0 the sequencer runs from address 0.
- It requests IEEE754 single-precision operands, applies simple float/integer operations and emits results.
- Top of the verification platform; no sub-blocks other than the ROM array.

Parameters:
- ROM_SIZE, 16384, ROM depth in bytes; addresses are 14 bits.
- NREGS, 4, general registers R0..R3, 32 bits each.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sw_din  in  8  ROM write data.
- we_n_in  in  1  ROM write enable, active-low; honoured only when `mode`=1.
- sw_addr  in  14  ROM write address.
- mode  in  1  1 = load mode, sequencer held idle; 0 = run.
- din  in  32  operand data from host.
- din_rdy  in  1  host qualifies `din` (level).
- dout  out  32  result data; holds last output value.
- dout_rdy  out  1  one-cycle result strobe.
- din_req  out  1  sequencer requests an operand.

Behaviour:
- Reset (`rst`=0, async):
  - PC=0, R0..R3=0, `dout`=0, `dout_rdy`=0, `din_req`=0, state FETCH.
  - ROM contents are NOT cleared by reset.
- Load mode (`mode`=1):
  - On each clk edge with `we_n_in`=0, ROM[`sw_addr`] <= `sw_din`.
  - Sequencer forced to PC=0, state FETCH, `din_req`=0, `dout_rdy`=0.
  - Registers and `dout` keep their values.
  - Leaving load mode starts execution at address 0.
- ROM read is synchronous, 1-cycle latency. PC is 14 bits and wraps 16383->0.
- States:
  - FETCH: issue PC.
  - DECODE: latch opcode, PC+1.
  - OPER: fetch operand bytes, one per 2 cycles.
  - EXEC.
  - WAIT_IN.
  - HALT: terminal until reset or load mode.
- Operand byte r: register index = bits[1:0]; bits[7:2] ignored.
- Opcodes:
  - 0x00 NOP.
  - 0x01 IN r: enter WAIT_IN, `din_req`=1. On the first rising edge with `din_req`=1 and `din_rdy`=1: R[r] <= `din`, `din_req`=0 next cycle, continue. If `din_rdy` is already high on entry, completion takes 1 cycle.
  - 0x02 OUT r: `dout` <= R[r]; `dout_rdy`=1 for exactly one cycle. Consecutive OUTs are separated by >=1 low cycle because the next fetch intervenes.
  - 0x03 LDI r,b0,b1,b2,b3: R[r] <= {b3,b2,b1,b0} (little-endian).
  - 0x04 ADD r,s: R[r] <= R[r]+R[s], mod 2^32.
  - 0x05 FNEG r: flip R[r][31].
  - 0x06 FMUL2 r: IEEE754 x2.
    - exp==0 (zero/denormal): mantissa <<1, carry into exponent.
    - exp==255 (inf/NaN): unchanged.
    - exp==254: result becomes signed infinity.
    - Otherwise exp+1.
  - 0x07 JMP a_lo,a_hi: PC <= {a_hi[5:0],a_lo}.
  - 0xFF HALT.
  - Any other opcode: NOP (see optional feature).
- `mode` rising to 1 mid-instruction aborts the instruction. Pending `din_req` drops next cycle.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an undefined opcode enters HALT with PC pointing at the offending byte.
- ILLEGAL_TRAP_EN undefined: an undefined opcode executes as a 1-byte NOP.

Test Plan:
- Reset: drive `rst`=0 mid-run -> `dout`=0, `dout_rdy`=0, `din_req`=0 immediately. ROM contents unchanged, so the rerun after `rst`=1 gives identical results.
- Load then run program 01 00 06 00 02 00 05 00 02 00 FF:
  - `din_req` rises; give `din`=0x40200000 (2.5) with `din_rdy`=1.
  - `dout_rdy` pulses with `dout`=0x40A00000 (5.0), drops low, pulses with 0xC0A00000 (-5.0), then HALT.
- Handshake stall: keep `din_rdy`=0 for 50 cycles -> `din_req` stays 1 and there is no progress. Assert `din_rdy` -> value captured, `din_req` low next cycle.
- FMUL2 edges:
  - 0x7F000000 -> 0x7F800000.
  - 0x7FC00000 -> unchanged.
  - 0x00400000 -> 0x00800000.
  - 0x80000000 -> 0x80000000.
- LDI/ADD/JMP: LDI R1=0xFFFFFFFF, LDI R2=2, ADD R1,R2, OUT R1 -> `dout`=0x00000001. A JMP back to the OUT -> repeated strobes of the same value.
- Undefined opcode 0x42 before OUT:
  - Without ILLEGAL_TRAP_EN -> OUT still strobes.
  - With ILLEGAL_TRAP_EN -> no `dout_rdy` ever.
